// File: rtl/contador_segundos_if.sv
// Bus between the seconds stage and its surroundings: run/clear/button
// controls in, seconds value and the tick / minute-advance pulses out.
interface contador_segundos_if;
  logic       enable;
  logic       clearSeg;
  logic       btnMin;
  logic [5:0] segundos;
  logic       modifMin;
  logic       tick;

  modport master (
    output enable, clearSeg, btnMin,
    input  segundos, modifMin, tick
  );

  modport slave (
    input  enable, clearSeg, btnMin,
    output segundos, modifMin, tick
  );
endinterface

// File: rtl/contador_segundos.sv
// Seconds stage of the digital clock: 1 Hz prescaler, 0-59 seconds counter,
// debounced "advance minute" button merged with the carry onto modifMin.
module contador_segundos #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input logic                clock,
  input logic                reset,
  contador_segundos_if.slave bus
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  // Bit 1 of the state is the modifMin flop itself, bit 0 the pending flag.
  typedef enum logic [1:0] {
    ARB_IDLE       = 2'b00,
    ARB_PEND       = 2'b01,
    ARB_PULSE      = 2'b10,
    ARB_PULSE_PEND = 2'b11
  } arbState_t;

  arbState_t       arbState, arbNext;
  logic [PW-1:0]   presc;
  logic [5:0]      segCount;
  logic            tickReg;
  logic            syncA, syncB;
  logic [DW-1:0]   debCount;
  logic            debLevel, debPrev;
  logic            tickNow, carry, manReq, reqAny;

  assign tickNow = bus.enable && (presc == PRESC_MAX);
  assign carry   = tickNow && !bus.clearSeg && (segCount == 6'd59);
  assign manReq  = debLevel && !debPrev;
  assign reqAny  = manReq || arbState[0];

  assign bus.segundos = segCount;
  assign bus.tick     = tickReg;
  assign bus.modifMin = arbState[1];

  // clearSeg outranks the tick so a clear on the wrap edge never carries.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      segCount <= '0;
      tickReg  <= 1'b0;
    end else if (bus.clearSeg) begin
      presc    <= '0;
      segCount <= '0;
      tickReg  <= 1'b0;
    end else if (tickNow) begin
      presc    <= '0;
      tickReg  <= 1'b1;
      segCount <= (segCount == 6'd59) ? 6'd0 : segCount + 6'd1;
    end else begin
      tickReg <= 1'b0;
      if (bus.enable) presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncA    <= 1'b0;
      syncB    <= 1'b0;
      debCount <= '0;
      debLevel <= 1'b0;
      debPrev  <= 1'b0;
    end else begin
      syncA   <= bus.btnMin;
      syncB   <= syncA;
      debPrev <= debLevel;
      if (syncB != debLevel) begin
        if (debCount == DEB_LAST) begin
          debLevel <= ~debLevel;
          debCount <= '0;
        end else begin
          debCount <= debCount + 1'b1;
        end
      end else begin
        debCount <= '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) arbState <= ARB_IDLE;
    else       arbState <= arbNext;
  end

  // A carry always wins; a manual request waits for a low cycle and is
  // folded into the single pending slot, so extra presses are dropped.
  always_comb begin
    arbNext = ARB_IDLE;
    if (carry)
      arbNext = reqAny ? ARB_PULSE_PEND : ARB_PULSE;
    else if (!arbState[1] && reqAny)
      arbNext = ARB_PULSE;
    else if (reqAny)
      arbNext = ARB_PEND;
  end

endmodule

// File: tb/tb_contador_segundos.sv
// Self-checking bench for contador_segundos: two instances (slow and fast
// debounce) checked every cycle against a time/event model plus literals.
module tb_contador_segundos;

  localparam int CLK_HZ = 4;
  localparam int DEB0   = 3;
  localparam int DEB1   = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable, clearSeg, btn0, btn1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  contador_segundos_if bus0 ();
  contador_segundos_if bus1 ();

  assign bus0.enable   = enable;
  assign bus0.clearSeg = clearSeg;
  assign bus0.btnMin   = btn0;
  assign bus1.enable   = enable;
  assign bus1.clearSeg = clearSeg;
  assign bus1.btnMin   = btn1;

  contador_segundos #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0.slave));
  contador_segundos #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1.slave));

  // Model state: elapsed enabled cycles since clear/reset gives time directly;
  // the button is tracked as a sampled level history and a run length.
  int   elapsed[2];
  int   runLen[2];
  int   mSeg[2];
  logic mTick[2], mMod[2], pend[2];
  logic smp1[2], smp2[2], lvl[2], lvlPrev[2];

  function automatic int debOf(input int i);
    return (i == 0) ? DEB0 : DEB1;
  endfunction

  task automatic modelReset(input int i);
    elapsed[i] = 0; runLen[i] = 0; mSeg[i] = 0;
    mTick[i] = 0; mMod[i] = 0; pend[i] = 0;
    smp1[i] = 0; smp2[i] = 0; lvl[i] = 0; lvlPrev[i] = 0;
  endtask

  task automatic modelStep(input int i, input logic btn);
    logic req, carry, newMod;
    req        = lvl[i] && !lvlPrev[i];
    lvlPrev[i] = lvl[i];
    if (smp2[i] != lvl[i]) begin
      runLen[i]++;
      if (runLen[i] == debOf(i)) begin
        lvl[i]    = !lvl[i];
        runLen[i] = 0;
      end
    end else begin
      runLen[i] = 0;
    end
    smp2[i] = smp1[i];
    smp1[i] = btn;

    carry = 0;
    if (clearSeg) begin
      elapsed[i] = 0;
      mTick[i]   = 0;
    end else if (enable) begin
      elapsed[i]++;
      mTick[i] = (elapsed[i] % CLK_HZ) == 0;
      carry    = mTick[i] && ((elapsed[i] / CLK_HZ) % 60 == 0);
    end else begin
      mTick[i] = 0;
    end
    mSeg[i] = (elapsed[i] / CLK_HZ) % 60;

    if (carry) begin
      newMod = 1;
      if (req) pend[i] = 1;
    end else if (!mMod[i] && (req || pend[i])) begin
      newMod  = 1;
      pend[i] = 0;
    end else begin
      newMod = 0;
      if (req) pend[i] = 1;
    end
    mMod[i] = newMod;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      modelReset(0);
      modelReset(1);
    end else begin
      modelStep(0, btn0);
      modelStep(1, btn1);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle both instances must match the model.
  always @(negedge clock) begin
    if (checks >= 0 && $time > 5) begin
      checkOutput("model seg0",  32'(bus0.segundos), 32'(mSeg[0]));
      checkOutput("model tick0", 32'(bus0.tick),     32'(mTick[0]));
      checkOutput("model mod0",  32'(bus0.modifMin), 32'(mMod[0]));
      checkOutput("model seg1",  32'(bus1.segundos), 32'(mSeg[1]));
      checkOutput("model tick1", 32'(bus1.tick),     32'(mTick[1]));
      checkOutput("model mod1",  32'(bus1.modifMin), 32'(mMod[1]));
    end
  end

  // Sets the inputs for the next rising edge, then returns at the sampling point.
  task automatic applyStimulus(input logic en, input logic clr, input logic b0, input logic b1);
    enable   = en;
    clearSeg = clr;
    btn0     = b0;
    btn1     = b1;
    @(negedge clock);
  endtask

  initial begin
    int tickCount, modCount;
    logic b0, b1;
    enable = 0; clearSeg = 0; btn0 = 0; btn1 = 0;
    #1 reset = 1;
    @(negedge clock);
    checkOutput("reset seg",  32'(bus0.segundos), 0);
    checkOutput("reset tick", 32'(bus0.tick),     0);
    checkOutput("reset mod",  32'(bus0.modifMin), 0);
    reset = 0;

    // Reset mid-count at 37 s, prescaler 2
    repeat (150) applyStimulus(1, 0, 0, 0);
    checkOutput("count to 37", 32'(bus0.segundos), 37);
    #2 reset = 1;
    #1;
    checkOutput("async reset seg",  32'(bus0.segundos), 0);
    checkOutput("async reset tick", 32'(bus0.tick),     0);
    checkOutput("async reset mod",  32'(bus0.modifMin), 0);
    @(negedge clock);
    reset = 0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("first tick", 32'(bus0.tick), 32'(k == 4));
    end
    checkOutput("first tick seg", 32'(bus0.segundos), 1);

    // Full minute from a clear: 60 ticks, one carry pulse at the wrap
    applyStimulus(1, 1, 0, 0);
    tickCount = 0;
    modCount  = 0;
    for (int k = 1; k <= 240; k++) begin
      applyStimulus(1, 0, 0, 0);
      tickCount += int'(bus0.tick);
      modCount  += int'(bus0.modifMin);
      if (k == 239) checkOutput("seg 59", 32'(bus0.segundos), 59);
    end
    checkOutput("wrap seg",    32'(bus0.segundos), 0);
    checkOutput("wrap mod",    32'(bus0.modifMin), 1);
    checkOutput("tick count",  32'(tickCount), 60);
    checkOutput("carry count", 32'(modCount),  1);

    // Pause at prescaler 2, then resume
    repeat (2) applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("paused tick", 32'(bus0.tick),     0);
      checkOutput("paused seg",  32'(bus0.segundos), 0);
    end
    applyStimulus(1, 0, 0, 0);
    checkOutput("resume tick a", 32'(bus0.tick), 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("resume tick b", 32'(bus0.tick), 1);
    checkOutput("resume seg",    32'(bus0.segundos), 1);

    // Bouncing press then stable high: one pulse 6 edges in, none on release
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("bounce quiet", 32'(bus0.modifMin), 0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1, 0, 1, 0);
      checkOutput("press pulse", 32'(bus0.modifMin), 32'(k == 6));
    end
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("release quiet", 32'(bus0.modifMin), 0);
    end

    // Manual request on the carry edge; fast instance also drops a second press
    applyStimulus(1, 1, 0, 0);
    for (int k = 1; k <= 250; k++) begin
      b0 = (k >= 235);
      b1 = (k == 237) || (k >= 239);
      applyStimulus(1, 0, b0, b1);
      if (k >= 238) begin
        checkOutput("collide mod0", 32'(bus0.modifMin), 32'(k == 240 || k == 242));
        checkOutput("collide mod1", 32'(bus1.modifMin), 32'(k == 240 || k == 242));
      end
    end
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("collide release", 32'(bus0.modifMin | bus1.modifMin), 0);
    end

    // Clear on the tick edge at 59 s: no tick, no carry, prescaler restarts
    applyStimulus(1, 1, 0, 0);
    repeat (239) applyStimulus(1, 0, 0, 0);
    checkOutput("pre-clear seg", 32'(bus0.segundos), 59);
    applyStimulus(1, 1, 0, 0);
    checkOutput("clear seg",  32'(bus0.segundos), 0);
    checkOutput("clear tick", 32'(bus0.tick),     0);
    checkOutput("clear mod",  32'(bus0.modifMin), 0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("post-clear tick", 32'(bus0.tick), 32'(k == 4));
      checkOutput("post-clear mod",  32'(bus0.modifMin), 0);
    end
    checkOutput("post-clear seg", 32'(bus0.segundos), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
